// File: rtl/irq_tick_timer.sv
// irq_tick_timer: N-channel programmable tick / interrupt generator.
// Ports: cfg_* write one channel's divisor/mode; ack W1C; pending/overrun/ei_req/irq_id out.
module irq_tick_timer #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 6249,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             cfg_oneshot,
  input  logic [N_CH-1:0]  ack,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overrun,
  output logic             ei_req,
  output logic [CH_W-1:0]  irq_id
);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] div_q [N_CH];
  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  os_q;
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  ovr_q;
  logic [N_CH-1:0]  cfg_hit;
  logic [N_CH-1:0]  wrap;
  logic [N_CH-1:0]  tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // an out-of-range cfg_ch matches no channel, so the write is dropped
    assign cfg_hit[g] = cfg_we && (cfg_ch == CH_W'(g));
    assign wrap[g]    = en_q[g] && (cnt_q[g] == div_q[g]);
    // a config write on this channel swallows a coincident tick
    assign tick[g]    = wrap[g] && !cfg_hit[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[g] <= '0;
        div_q[g] <= CNT_W'(DEFAULT_DIV);
        en_q[g]  <= 1'b0;
        os_q[g]  <= 1'b0;
      end else if (cfg_hit[g]) begin
        cnt_q[g] <= '0;
        div_q[g] <= cfg_div;
        en_q[g]  <= cfg_en;
        os_q[g]  <= cfg_oneshot;
      end else if (en_q[g]) begin
        if (wrap[g]) begin
          cnt_q[g] <= '0;
          if (os_q[g]) en_q[g] <= 1'b0;
        end else begin
          cnt_q[g] <= cnt_q[g] + CNT_W'(1);
        end
      end
    end

    // tick wins over ack so a new event is never lost
    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q[g] <= 1'b0;
        ovr_q[g]  <= 1'b0;
      end else if (tick[g]) begin
        pend_q[g] <= 1'b1;
        ovr_q[g]  <= ack[g] ? 1'b0 : (ovr_q[g] | pend_q[g]);
      end else if (ack[g]) begin
        pend_q[g] <= 1'b0;
        ovr_q[g]  <= 1'b0;
      end
    end
  end

  assign pending = pend_q;
  assign overrun = ovr_q;
  assign ei_req  = |pend_q;

  // scan high to low so the lowest pending index is the last one written
  always_comb begin
    irq_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) irq_id = CH_W'(i);
    end
  end

endmodule

// File: tb/tb_irq_tick_timer.sv
// tb_irq_tick_timer: directed self-checking bench for irq_tick_timer.
// Five channels so that cfg_ch == N_CH is representable on the port.
module tb_irq_tick_timer;

  localparam int N  = 5;
  localparam int CW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_oneshot = 1'b0;
  logic [N-1:0]  ack = '0;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;
  logic          ei_req;
  logic [IW-1:0] irq_id;

  int errors = 0;
  int checks = 0;

  irq_tick_timer #(
    .N_CH(N), .CNT_W(CW), .DEFAULT_DIV(6249)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_en(cfg_en),
    .cfg_oneshot(cfg_oneshot), .ack(ack),
    .pending(pending), .overrun(overrun),
    .ei_req(ei_req), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  // advance n rising edges; sample/drive 1ns after each edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle config write; the edge consumed here is "E0"
  task automatic cfg(input int ch, input int dv,
                     input logic en, input logic os);
    cfg_we = 1'b1;
    cfg_ch = IW'(ch);
    cfg_div = CW'(dv);
    cfg_en = en;
    cfg_oneshot = os;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++; if (pending !== 5'b0) begin errors++; $display("FAIL rst_pend got=%b exp=00000", pending); end
    checks++; if (overrun !== 5'b0) begin errors++; $display("FAIL rst_ovr got=%b exp=00000", overrun); end
    checks++; if (ei_req !== 1'b0) begin errors++; $display("FAIL rst_ei got=%b exp=0", ei_req); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", irq_id); end
    checks++; if (dut.div_q[0] !== 16'd6249) begin errors++; $display("FAIL rst_div got=%0d exp=6249", dut.div_q[0]); end
  endtask

  task automatic test_periodic();
    cfg(0, 9, 1'b1, 1'b0);
    step(9);
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL per_e9 got=%b exp=0", pending[0]); end
    step(1);
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL per_e10 got=%b exp=1", pending[0]); end
    checks++; if (ei_req !== 1'b1) begin errors++; $display("FAIL per_ei got=%b exp=1", ei_req); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL per_id got=%0d exp=0", irq_id); end
    step(1);
    ack = 5'b00001;
    step(1);
    ack = '0;
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL per_ack_e12 got=%b exp=0", pending[0]); end
    checks++; if (ei_req !== 1'b0) begin errors++; $display("FAIL per_ack_ei got=%b exp=0", ei_req); end
    step(7);
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL per_e19 got=%b exp=0", pending[0]); end
    step(1);
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL per_e20 got=%b exp=1", pending[0]); end
    checks++; if (overrun[0] !== 1'b0) begin errors++; $display("FAIL per_ovr got=%b exp=0", overrun[0]); end
    ack = 5'b00001;
    cfg(0, 9, 1'b0, 1'b0);
    ack = '0;
  endtask

  task automatic test_oneshot();
    cfg(1, 3, 1'b1, 1'b1);
    step(3);
    checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL os_e3 got=%b exp=0", pending[1]); end
    step(1);
    checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL os_e4 got=%b exp=1", pending[1]); end
    checks++; if (dut.en_q[1] !== 1'b0) begin errors++; $display("FAIL os_en got=%b exp=0", dut.en_q[1]); end
    ack = 5'b00010;
    step(1);
    ack = '0;
    step(35);
    checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL os_e40 got=%b exp=0", pending[1]); end
    checks++; if (overrun[1] !== 1'b0) begin errors++; $display("FAIL os_ovr got=%b exp=0", overrun[1]); end
  endtask

  task automatic test_overrun();
    cfg(2, 2, 1'b1, 1'b0);
    step(3);
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL ovr_e3_p got=%b exp=1", pending[2]); end
    checks++; if (overrun[2] !== 1'b0) begin errors++; $display("FAIL ovr_e3_o got=%b exp=0", overrun[2]); end
    step(3);
    checks++; if (overrun[2] !== 1'b1) begin errors++; $display("FAIL ovr_e6 got=%b exp=1", overrun[2]); end
    step(1);
    ack = 5'b00100;
    step(1);
    ack = '0;
    checks++; if ({pending[2], overrun[2]} !== 2'b00) begin errors++; $display("FAIL ovr_ack got=%b%b exp=00", pending[2], overrun[2]); end
    step(3);
    checks++; if ({pending[2], overrun[2]} !== 2'b10) begin errors++; $display("FAIL ovr_e11 got=%b%b exp=10", pending[2], overrun[2]); end
    ack = 5'b00100;
    step(1);
    ack = '0;
    checks++; if ({pending[2], overrun[2]} !== 2'b10) begin errors++; $display("FAIL ovr_ack_tick got=%b%b exp=10", pending[2], overrun[2]); end
    ack = 5'b00100;
    cfg(2, 2, 1'b0, 1'b0);
    ack = '0;
  endtask

  task automatic test_priority();
    cfg(0, 5, 1'b1, 1'b0);
    cfg(3, 5, 1'b1, 1'b0);
    step(5);
    checks++; if (pending !== 5'b00001) begin errors++; $display("FAIL pri_e6 got=%b exp=00001", pending); end
    step(1);
    checks++; if (pending !== 5'b01001) begin errors++; $display("FAIL pri_e7 got=%b exp=01001", pending); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL pri_id_both got=%0d exp=0", irq_id); end
    ack = 5'b00001;
    step(1);
    ack = '0;
    checks++; if (irq_id !== 3'd3) begin errors++; $display("FAIL pri_id3 got=%0d exp=3", irq_id); end
    checks++; if (ei_req !== 1'b1) begin errors++; $display("FAIL pri_ei3 got=%b exp=1", ei_req); end
    ack = 5'b01001;
    step(1);
    ack = '0;
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL pri_id_none got=%0d exp=0", irq_id); end
    checks++; if (ei_req !== 1'b0) begin errors++; $display("FAIL pri_ei_none got=%b exp=0", ei_req); end
    cfg(0, 5, 1'b0, 1'b0);
    cfg(3, 5, 1'b0, 1'b0);
    checks++; if (pending !== 5'b0) begin errors++; $display("FAIL pri_off got=%b exp=00000", pending); end
  endtask

  task automatic test_div_zero();
    cfg(4, 0, 1'b1, 1'b0);
    step(1);
    checks++; if ({pending[4], overrun[4]} !== 2'b10) begin errors++; $display("FAIL dz_e1 got=%b%b exp=10", pending[4], overrun[4]); end
    checks++; if (irq_id !== 3'd4) begin errors++; $display("FAIL dz_id got=%0d exp=4", irq_id); end
    step(1);
    checks++; if (overrun[4] !== 1'b1) begin errors++; $display("FAIL dz_e2 got=%b exp=1", overrun[4]); end
    ack = 5'b10000;
    cfg(4, 0, 1'b0, 1'b0);
    ack = '0;
    checks++; if (pending !== 5'b0) begin errors++; $display("FAIL dz_off got=%b exp=00000", pending); end
  endtask

  task automatic test_reconfig();
    cfg(0, 9, 1'b1, 1'b0);
    step(7);
    checks++; if (dut.cnt_q[0] !== 16'd7) begin errors++; $display("FAIL rc_cnt7 got=%0d exp=7", dut.cnt_q[0]); end
    cfg(0, 4, 1'b1, 1'b0);
    checks++; if (dut.cnt_q[0] !== 16'd0) begin errors++; $display("FAIL rc_cnt0 got=%0d exp=0", dut.cnt_q[0]); end
    step(4);
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL rc_e12 got=%b exp=0", pending[0]); end
    step(1);
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL rc_e13 got=%b exp=1", pending[0]); end
    cfg(N, 0, 1'b1, 1'b1);
    cfg(7, 0, 1'b1, 1'b1);
    checks++; if (pending !== 5'b00001) begin errors++; $display("FAIL rc_bad_pend got=%b exp=00001", pending); end
    checks++; if (dut.cnt_q[0] !== 16'd2) begin errors++; $display("FAIL rc_bad_cnt got=%0d exp=2", dut.cnt_q[0]); end
    checks++; if (dut.div_q[0] !== 16'd4) begin errors++; $display("FAIL rc_bad_div got=%0d exp=4", dut.div_q[0]); end
    checks++; if (dut.en_q !== 5'b00001) begin errors++; $display("FAIL rc_bad_en got=%b exp=00001", dut.en_q); end
    step(3);
    checks++; if (overrun[0] !== 1'b1) begin errors++; $display("FAIL rc_e18_ovr got=%b exp=1", overrun[0]); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if ({pending, overrun} !== 10'b0) begin errors++; $display("FAIL mr_flags got=%b_%b exp=0", pending, overrun); end
    checks++; if ({ei_req, irq_id} !== 4'b0) begin errors++; $display("FAIL mr_out got=%b/%0d exp=0/0", ei_req, irq_id); end
    checks++; if (dut.div_q[0] !== 16'd6249) begin errors++; $display("FAIL mr_div got=%0d exp=6249", dut.div_q[0]); end
    checks++; if (dut.en_q !== 5'b0) begin errors++; $display("FAIL mr_en got=%b exp=00000", dut.en_q); end
    step(10000);
    checks++; if (pending !== 5'b0) begin errors++; $display("FAIL mr_idle got=%b exp=00000", pending); end
    checks++; if (dut.cnt_q[0] !== 16'd0) begin errors++; $display("FAIL mr_cnt got=%0d exp=0", dut.cnt_q[0]); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_periodic();
    test_oneshot();
    test_overrun();
    test_priority();
    test_div_zero();
    test_reconfig();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_tick_timer.md
# irq_tick_timer

Multi-channel programmable tick/interrupt generator for the yrv MCU board tops. It generalises the fixed single-channel 8 kHz interrupt divider (6250 cycles at 50 MHz, latch cleared by software) to N independently programmable channels. Each channel supports periodic or one-shot mode, a latched pending flag, write-1-to-clear acknowledge and sticky overrun detection. It sits between the board clock and the MCU `ei_req` input; channel configuration comes from MCU port registers.

## Interface
- `N_CH`, 4, number of timer channels (1..16)
- `CNT_W`, 16, counter/divisor width in bits
- `DEFAULT_DIV`, 6249, reset reload value per channel (period = reload+1 cycles)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cfg_we`  in  1  configuration write strobe, one cycle
- `cfg_ch`  in  $clog2(N_CH) (min 1)  channel selected by `cfg_we`
- `cfg_div`  in  CNT_W  reload value; period = cfg_div+1 cycles
- `cfg_en`  in  1  channel enable written with `cfg_we`
- `cfg_oneshot`  in  1  1 = one-shot mode, 0 = periodic, written with `cfg_we`
- `ack`  in  N_CH  write-1-to-clear for pending and overrun, per channel, one cycle
- `pending`  out  N_CH  latched tick flags (registered)
- `overrun`  out  N_CH  sticky: tick occurred while already pending (registered)
- `ei_req`  out  1  OR of `pending`
- `irq_id`  out  $clog2(N_CH) (min 1)  index of lowest-numbered pending channel; 0 when none

## Operation
- Per channel state: `cnt[CNT_W]`, `div[CNT_W]`, `en`, `oneshot`, `pending`, `overrun`.
- Reset (`rst`=1 at an edge): `cnt`=0, `div`=DEFAULT_DIV, `en`=0, `oneshot`=0, `pending`=0, `overrun`=0. Outputs `ei_req`=0 and `irq_id`=0.
- Counting, when `en`=1: if `cnt`==`div`, a tick occurs, and `cnt`←0; otherwise `cnt`←`cnt`+1. When `en`=0, `cnt` holds.
- Tick effects:
  - `pending`←1.
  - If `pending` was already 1 and `ack` for that channel is 0 this cycle, `overrun`←1.
  - In one-shot mode, `en`←0 on the tick edge and `cnt`←0.
- `ack[i]`=1 clears `pending[i]` and `overrun[i]`.
- Tick and `ack` on the same channel in the same cycle: `pending`=1, `overrun`=0. The new event is never lost.
- `cfg_we` on channel c loads `div`, `en` and `oneshot`, and forces `cnt`←0. It leaves `pending` and `overrun` unchanged.
- `cfg_we` overrides any tick on channel c in that cycle: that tick is suppressed.
- `cfg_div`=0 gives a tick every enabled cycle.
- `cfg_ch` ≥ N_CH: the write is ignored.
- Wrap-around: `cnt` never exceeds `div`. No arithmetic overflow is possible, because the increment occurs only when `cnt`<`div`.
- `ei_req` and `irq_id` are combinational from the `pending` registers only, with a fixed priority encoder (lowest index wins).

## Timing
- Config write at edge E0 with en=1, div=D: first `pending` rises at edge E0+D+1.
  - Periodic mode: subsequent rises every D+1 edges, provided it was acked in between.
- `ack` asserted for the cycle before edge Ek: `pending` is low after Ek, unless a tick coincides at Ek.
- `ei_req`/`irq_id` follow `pending` with zero added latency.
- A synchronous reset mid-count takes effect at that edge. No tick is generated on the reset edge.

## Test plan
- Reset, then cfg ch0 div=9 en=1 periodic at E0.
  - Required: `pending[0]` rises at E10.
  - Ack at E12: `pending[0]` clears at E12 and rises again at E20. `ei_req` follows, `irq_id`=0.
- Ch1 div=3 one-shot, written at E0.
  - Required: `pending[1]` rises at E4, and `en` drops at E4.
  - No further tick through E40, even after ack.
- Ch2 div=2, no ack.
  - Required: `pending[2]` rises at E3 and `overrun[2]` rises at E6.
  - Ack at E8 with no coincident tick: both flags are 0.
  - Repeat with ack exactly on a tick edge: `pending`=1, `overrun`=0.
- Ch0 div=5 and ch3 div=5 written on consecutive cycles.
  - Required: `irq_id`=0 while both are pending.
  - After ack of ch0, `irq_id`=3 with `ei_req`=1. After acking both, `irq_id`=0 and `ei_req`=0.
- Reconfigure ch0 mid-count: div=9 running, at cnt=7 write div=4.
  - Required: `cnt`→0 and the next tick is 5 edges later.
  - `cfg_we` with `cfg_ch`=N_CH leaves all channels unchanged.
- Assert `rst` for one cycle mid-operation with flags set.
  - Required: all outputs 0 next cycle, `div` back to 6249, and no ticks with `en`=0 for 10000 cycles.
